// File: rtl/spike_packet_tx.sv
// Serialises each timestep's spike snapshot into {tail, node_id, neuron_idx, timestep} packets.
// Build option: SPIKE_PKT_TAIL_EN appends an end-of-timestep tail packet to every accepted snapshot.
module spike_packet_tx #(
  parameter int NUM_NEURONS = 16,
  parameter int NODE_ID_W   = 8,
  parameter int TS_W        = 8,
  localparam int IDX_W      = $clog2(NUM_NEURONS),
  localparam int PKT_W      = 1 + NODE_ID_W + IDX_W + TS_W
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [NUM_NEURONS-1:0] spikes,
  input  logic [NODE_ID_W-1:0]   node_id,
  input  logic                   pkt_ready,
  output logic                   pkt_valid,
  output logic [PKT_W-1:0]       pkt_data,
  output logic                   busy,
  output logic                   overrun
);

  // state | meaning
  // IDLE  | no snapshot in flight, a boundary is accepted immediately
  // SEND  | presenting spike packets, lowest remaining neuron first
  // TAIL  | presenting the end-of-timestep marker (tail builds only)
`ifdef SPIKE_PKT_TAIL_EN
  typedef enum logic [1:0] {IDLE, SEND, TAIL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND} state_t;
`endif

  state_t                 state, state_n;
  logic [NUM_NEURONS-1:0] pending, pending_n, rem;
  logic [TS_W-1:0]        ts_cnt, ts_cnt_n, ts_tag, ts_tag_n;
  logic                   clear_d;
  logic                   valid_n, overrun_n;
  logic [PKT_W-1:0]       data_n;
  logic                   boundary, hs, done;

  function automatic logic [IDX_W-1:0] low_idx(input logic [NUM_NEURONS-1:0] v);
    low_idx = '0;
    for (int i = NUM_NEURONS - 1; i >= 0; i--)
      if (v[i]) low_idx = IDX_W'(i);
  endfunction

  assign boundary = clear && !clear_d;
  assign hs       = pkt_valid && pkt_ready;
  // pending still holds the bit on the wire; rem is what is left once it is accepted
  assign rem      = pending & (pending - NUM_NEURONS'(1));
  assign busy     = (state != IDLE);

  always_comb begin
    state_n   = state;
    pending_n = pending;
    ts_cnt_n  = ts_cnt;
    ts_tag_n  = ts_tag;
    valid_n   = pkt_valid;
    data_n    = pkt_data;
    overrun_n = overrun;
    done      = 1'b0;

    case (state)
      SEND: begin
        if (hs) begin
          pending_n = rem;
          if (rem != '0) begin
            data_n = {1'b0, node_id, low_idx(rem), ts_tag};
          end else begin
`ifdef SPIKE_PKT_TAIL_EN
            state_n = TAIL;
            data_n  = {1'b1, node_id, {IDX_W{1'b0}}, ts_tag};
`else
            state_n = IDLE;
            valid_n = 1'b0;
            done    = 1'b1;
`endif
          end
        end
      end
`ifdef SPIKE_PKT_TAIL_EN
      TAIL: begin
        if (hs) begin
          state_n = IDLE;
          valid_n = 1'b0;
          done    = 1'b1;
        end
      end
`endif
      default: ;
    endcase

    // a boundary that coincides with the final handshake is taken without a gap
    if (boundary) begin
      ts_cnt_n = ts_cnt + TS_W'(1);
      if (state == IDLE || done) begin
        pending_n = spikes;
        ts_tag_n  = ts_cnt;
        if (spikes != '0) begin
          state_n = SEND;
          valid_n = 1'b1;
          data_n  = {1'b0, node_id, low_idx(spikes), ts_cnt};
        end else begin
`ifdef SPIKE_PKT_TAIL_EN
          state_n = TAIL;
          valid_n = 1'b1;
          data_n  = {1'b1, node_id, {IDX_W{1'b0}}, ts_cnt};
`else
          state_n = IDLE;
          valid_n = 1'b0;
`endif
        end
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= IDLE;
      pending   <= '0;
      ts_cnt    <= '0;
      ts_tag    <= '0;
      clear_d   <= 1'b0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      ts_cnt    <= ts_cnt_n;
      ts_tag    <= ts_tag_n;
      clear_d   <= clear;
      pkt_valid <= valid_n;
      pkt_data  <= data_n;
      overrun   <= overrun_n;
    end
  end

endmodule

// File: tb/tb_spike_packet_tx.sv
// Bench for spike_packet_tx: directed scenarios plus random traffic against a packet-queue model.
module tb_spike_packet_tx;

`ifdef SPIKE_PKT_TAIL_EN
  localparam int TAIL_N = 1;
`else
  localparam int TAIL_N = 0;
`endif

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] spikes = '0;
  logic [7:0]  node_id = 8'h05;
  logic        pkt_ready = 1'b1;
  logic        pkt_valid;
  logic [20:0] pkt_data;
  logic        busy;
  logic        overrun;

  spike_packet_tx #(.NUM_NEURONS(16), .NODE_ID_W(8), .TS_W(8)) dut (
    .CLK(CLK), .reset(reset), .clear(clear), .spikes(spikes), .node_id(node_id),
    .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_data(pkt_data),
    .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;

  // model: every packet still owed by the current snapshot, in emission order
  logic [20:0] exp_q[$];
  logic [20:0] got_q[$];
  logic [7:0]  m_ts;
  logic        m_ovr;
  logic        m_clear_d;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_load(input logic [15:0] s, input logic [7:0] ts);
    for (int i = 0; i < 16; i++)
      if (s[i]) exp_q.push_back({1'b0, node_id, 4'(i), ts});
    if (TAIL_N != 0) exp_q.push_back({1'b1, node_id, 4'h0, ts});
  endtask

  task automatic model_edge();
    logic idle_before, hs, done, ev;
    if (reset) begin
      exp_q.delete();
      m_ts = '0; m_ovr = 1'b0; m_clear_d = 1'b0;
      return;
    end
    idle_before = (exp_q.size() == 0);
    hs = !idle_before && pkt_ready;
    if (hs) void'(exp_q.pop_front());
    done = hs && (exp_q.size() == 0);
    ev = clear && !m_clear_d;
    m_clear_d = clear;
    if (ev) begin
      if (idle_before || done) model_load(spikes, m_ts);
      else m_ovr = 1'b1;
      m_ts = m_ts + 8'd1;
    end
  endtask

  task automatic step(input logic c, input logic [15:0] s, input logic r);
    clear = c; spikes = s; pkt_ready = r;
    if (!reset && pkt_valid && pkt_ready) got_q.push_back(pkt_data);
    model_edge();
    @(posedge CLK);
    @(negedge CLK);
    check_val("valid", 32'(pkt_valid), 32'(exp_q.size() != 0));
    check_val("busy", 32'(busy), 32'(exp_q.size() != 0));
    check_val("overrun", 32'(overrun), 32'(m_ovr));
    if (exp_q.size() != 0) check_val("data", 32'(pkt_data), 32'(exp_q[0]));
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, r);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    reset = 1'b0;
  endtask

  logic [20:0] held;
  int          cnt;

  initial begin
    @(negedge CLK);
    // 1: reset and idle
    do_reset();
    check_val("rst_data", 32'(pkt_data), 32'h0);
    got_q.delete();
    idle(3, 1'b1);
    check_val("idle_pkts", 32'(got_q.size()), 32'd0);

    // 2: three back-to-back packets, then next event tags ts=1
    step(1'b1, 16'h8005, 1'b1);
    idle(5, 1'b1);
    check_val("t2_count", 32'(got_q.size()), 32'(3 + TAIL_N));
    if (got_q.size() >= 3) begin
      check_val("t2_idx0", 32'(got_q[0][11:8]), 32'd0);
      check_val("t2_idx1", 32'(got_q[1][11:8]), 32'd2);
      check_val("t2_idx2", 32'(got_q[2][11:8]), 32'd15);
      check_val("t2_ts", 32'(got_q[2][7:0]), 32'd0);
      check_val("t2_tail", 32'(got_q[2][20]), 32'd0);
      check_val("t2_node", 32'(got_q[0][19:12]), 32'h05);
    end
    check_val("t2_busy", 32'(busy), 32'd0);
    step(1'b1, 16'h0001, 1'b1);
    check_val("t2_ts1", 32'(pkt_data[7:0]), 32'd1);
    idle(4, 1'b1);

    // 3: stall on idx 2
    step(1'b1, 16'h8005, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    held = pkt_data;
    check_val("t3_idx2", 32'(held[11:8]), 32'd2);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h0, 1'b0);
      check_val("t3_stable", 32'(pkt_data), 32'(held));
    end
    step(1'b0, 16'h0, 1'b1);
    check_val("t3_idx15", 32'(pkt_data[11:8]), 32'd15);
    idle(4, 1'b1);

    // 4: overrun while stalled on a full snapshot
    do_reset();
    got_q.delete();
    step(1'b1, 16'hFFFF, 1'b0);
    step(1'b0, 16'h0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0);
    check_val("t4_overrun", 32'(overrun), 32'd1);
    step(1'b0, 16'h0, 1'b1);
    idle(20, 1'b1);
    check_val("t4_sticky", 32'(overrun), 32'd1);
    cnt = 0;
    foreach (got_q[i]) if (got_q[i][7:0] == 8'd0 && !got_q[i][20]) cnt++;
    check_val("t4_count", 32'(cnt), 32'd16);
    check_val("t4_total", 32'(got_q.size()), 32'(16 + TAIL_N));
    step(1'b1, 16'h0001, 1'b1);
    check_val("t4_ts2", 32'(pkt_data[7:0]), 32'd2);
    idle(4, 1'b1);

    // 5: clear held high is one event
    got_q.delete();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h0001, 1'b1);
    idle(4, 1'b1);
    check_val("t5_count", 32'(got_q.size()), 32'(1 + TAIL_N));

    // 6: reset mid-drain
    step(1'b1, 16'h00F0, 1'b1);
    step(1'b0, 16'h0, 1'b1);
    reset = 1'b1;
    step(1'b0, 16'h0, 1'b1);
    reset = 1'b0;
    check_val("t6_valid", 32'(pkt_valid), 32'd0);
    check_val("t6_busy", 32'(busy), 32'd0);
    check_val("t6_data", 32'(pkt_data), 32'd0);
    step(1'b1, 16'h0001, 1'b1);
    check_val("t6_ts0", 32'(pkt_data[7:0]), 32'd0);
    idle(4, 1'b1);

    // 7: empty snapshot, and a single spike
    do_reset();
    step(1'b1, 16'h0000, 1'b1);
`ifdef SPIKE_PKT_TAIL_EN
    check_val("t7_tail", 32'(pkt_data), 32'({1'b1, 8'h05, 4'h0, 8'h00}));
`else
    check_val("t7_empty", 32'(pkt_valid), 32'd0);
`endif
    step(1'b0, 16'h0, 1'b1);
    got_q.delete();
    step(1'b1, 16'h0002, 1'b1);
    idle(4, 1'b1);
    check_val("t7_count", 32'(got_q.size()), 32'(1 + TAIL_N));
    if (got_q.size() >= 1) check_val("t7_idx1", 32'(got_q[0][11:8]), 32'd1);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      logic        c, r;
      logic [15:0] s;
      c = ($urandom_range(0, 5) == 0) ? ~clear : clear;
      r = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: s = 16'h0;
        1: s = 16'(1 << $urandom_range(0, 15));
        default: s = 16'($urandom);
      endcase
      if ($urandom_range(0, 499) == 0) reset = 1'b1;
      step(c, s, r);
      reset = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
